voice_am_scheduler: RTL

VOICE_AM_SCHEDULER -- requirements
Module: voice_am_scheduler

---
 rtl/sid_pkg.sv | 12 +
 rtl/am_mult_pipe.sv | 54 +++++
 rtl/voice_am_scheduler.sv | 131 +++++++++++++
 3 files changed

// File: rtl/sid_pkg.sv
// Shared SID voice constants and the voice index type.
package sid_pkg;

  localparam int unsigned NUM_VOICES_DEF = 3;
  localparam int unsigned ENV_W_DEF      = 8;
  localparam int unsigned WAVE_W_DEF     = 12;
  localparam int unsigned WAVE_MID       = 2048;
  localparam int unsigned VOICE_IDX_W    = $clog2(NUM_VOICES_DEF);

  typedef logic [VOICE_IDX_W-1:0] voice_idx_t;

endpackage

// File: rtl/am_mult_pipe.sv
// Amplitude-modulation datapath: registered signed product (stage 1), then a
// combinational shift/offset (stage 2) that the caller registers into its output.
module am_mult_pipe
  import sid_pkg::*;
#(
  parameter int unsigned ENV_W  = ENV_W_DEF,
  parameter int unsigned WAVE_W = WAVE_W_DEF,
  parameter int unsigned TAG_W  = $bits(voice_idx_t)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [ENV_W-1:0]  in_env,
  input  logic [WAVE_W-1:0] in_wave,
  output logic              res_valid,
  output logic [TAG_W-1:0]  res_tag,
  output logic [WAVE_W-1:0] res_wave
);

  localparam int unsigned PROD_W = WAVE_W + ENV_W;
  localparam logic [WAVE_W-1:0] MID_CODE = {1'b1, {(WAVE_W-1){1'b0}}};

  logic signed [PROD_W-1:0] wave_x, env_x, prod_d, prod_q;
  logic                     s1_valid_q;
  logic [TAG_W-1:0]         s1_tag_q;

  always_comb begin
    // Offset-binary minus mid-scale is just an MSB flip, then sign-extend.
    wave_x = {{ENV_W{~in_wave[WAVE_W-1]}}, ~in_wave[WAVE_W-1], in_wave[WAVE_W-2:0]};
    env_x  = {{WAVE_W{1'b0}}, in_env};
    prod_d = wave_x * env_x;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid) begin
      prod_q   <= prod_d;
      s1_tag_q <= in_tag;
    end
  end

  assign res_valid = s1_valid_q;
  assign res_tag   = s1_tag_q;
  assign res_wave  = WAVE_W'(prod_q >>> ENV_W) + MID_CODE;

endmodule

// File: rtl/voice_am_scheduler.sv
// Shares one AM multiplier between SID voices with round-robin grant of pending samples.
// Optional per-voice muting is built when AM_SCHED_MUTE_EN is defined.
module voice_am_scheduler
  import sid_pkg::*;
#(
  parameter int unsigned NUM_VOICES = NUM_VOICES_DEF,
  parameter int unsigned ENV_W      = ENV_W_DEF,
  parameter int unsigned WAVE_W     = WAVE_W_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_VOICES-1:0]        sample_req,
  input  logic [NUM_VOICES*ENV_W-1:0]  envelope_in,
  input  logic [NUM_VOICES*WAVE_W-1:0] wave_in,
`ifdef AM_SCHED_MUTE_EN
  input  logic [NUM_VOICES-1:0]        mute,
`endif
  output logic [NUM_VOICES*WAVE_W-1:0] wave_out,
  output logic [NUM_VOICES-1:0]        out_valid,
  output logic [NUM_VOICES-1:0]        overrun,
  input  logic                         overrun_clr,
  output logic                         busy
);

  localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [WAVE_W-1:0] MID_CODE = {1'b1, {(WAVE_W-1){1'b0}}};

  logic [ENV_W-1:0]  env_q  [NUM_VOICES];
  logic [WAVE_W-1:0] wave_q [NUM_VOICES];
  logic [NUM_VOICES-1:0] pending_q, pending_d, overrun_q, overrun_d, grant_oh;
  logic [IDX_W-1:0]      last_q, grant_idx;
  logic                  grant_vld;
  logic [ENV_W-1:0]      grant_env;

  // Search starts one past the last granted voice and wraps.
  always_comb begin
    int cand;
    cand      = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = 1; i <= int'(NUM_VOICES); i++) begin
      cand = (int'(last_q) + i) % int'(NUM_VOICES);
      if (!grant_vld && pending_q[cand]) begin
        grant_vld = 1'b1;
        grant_idx = IDX_W'(cand);
      end
    end
    grant_oh = NUM_VOICES'(grant_vld) << grant_idx;
  end

  // A request on the voice being granted refills the slot without an overrun.
  always_comb begin
    pending_d = sample_req | (pending_q & ~grant_oh);
    overrun_d = (sample_req & pending_q & ~grant_oh) | (overrun_clr ? '0 : overrun_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
      overrun_q <= '0;
      last_q    <= IDX_W'(NUM_VOICES - 1);
    end else begin
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      if (grant_vld) last_q <= grant_idx;
    end
  end

  always_ff @(posedge clk) begin
    for (int v = 0; v < int'(NUM_VOICES); v++) begin
      if (sample_req[v]) begin
        env_q[v]  <= envelope_in[v*ENV_W +: ENV_W];
        wave_q[v] <= wave_in[v*WAVE_W +: WAVE_W];
      end
    end
  end

`ifdef AM_SCHED_MUTE_EN
  assign grant_env = mute[grant_idx] ? '0 : env_q[grant_idx];
`else
  assign grant_env = env_q[grant_idx];
`endif

  logic              res_vld;
  logic [IDX_W-1:0]  res_tag;
  logic [WAVE_W-1:0] res_wave;

  am_mult_pipe #(
    .ENV_W  (ENV_W),
    .WAVE_W (WAVE_W),
    .TAG_W  (IDX_W)
  ) u_mult (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (grant_vld),
    .in_tag    (grant_idx),
    .in_env    (grant_env),
    .in_wave   (wave_q[grant_idx]),
    .res_valid (res_vld),
    .res_tag   (res_tag),
    .res_wave  (res_wave)
  );

  logic [NUM_VOICES*WAVE_W-1:0] wave_out_q, wave_out_d;
  logic [NUM_VOICES-1:0]        out_valid_q, out_valid_d;

  always_comb begin
    wave_out_d  = wave_out_q;
    out_valid_d = '0;
    if (res_vld) begin
      out_valid_d = NUM_VOICES'(1) << res_tag;
      wave_out_d[int'(res_tag)*WAVE_W +: WAVE_W] = res_wave;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wave_out_q  <= {NUM_VOICES{MID_CODE}};
      out_valid_q <= '0;
    end else begin
      wave_out_q  <= wave_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign wave_out  = wave_out_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign busy      = (|pending_q) | res_vld | (|out_valid_q);

endmodule
